// File: rtl/centroid_pkg.sv
// centroid_pkg: shared widths, image defaults and FSM state
// encoding for the centroid divide scheduler.
package centroid_pkg;

  localparam int MOM_W      = 19;
  localparam int DIVIDEND_W = 28;
  localparam int DIVISOR_W  = 20;
  localparam int COORD_W    = 10;

  localparam int IMG_W_DEF   = 720;
  localparam int IMG_H_DEF   = 576;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_X = 3'd1,
    WAIT_X  = 3'd2,
    START_Y = 3'd3,
    WAIT_Y  = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/centroid_div_sched_if.sv
// centroid_div_sched_if: link to the shared 28/20 divider.
// master = scheduler (start/dividend/divisor), slave = divider.
interface centroid_div_sched_if;
  import centroid_pkg::*;

  logic                  div_start;
  logic [DIVIDEND_W-1:0] div_dividend;
  logic [DIVISOR_W-1:0]  div_divisor;
  logic [DIVIDEND_W-1:0] div_quotient;
  logic                  div_qv;

  modport master (
    output div_start, div_dividend, div_divisor,
    input  div_quotient, div_qv
  );

  modport slave (
    input  div_start, div_dividend, div_divisor,
    output div_quotient, div_qv
  );
endinterface

// File: rtl/coord_clamp.sv
// coord_clamp: saturates a 28-bit quotient to a 10-bit limit.
// quo_i: raw quotient, lim_i: max coordinate, coord_o: result.
module coord_clamp
  import centroid_pkg::*;
(
  input  logic [DIVIDEND_W-1:0] quo_i,
  input  logic [COORD_W-1:0]    lim_i,
  output logic [COORD_W-1:0]    coord_o
);
  assign coord_o = (quo_i > DIVIDEND_W'(lim_i))
                 ? lim_i : quo_i[COORD_W-1:0];
endmodule

// File: rtl/centroid_div_sched.sv
// centroid_div_sched: per-frame m10/m00, m01/m00 on one divider.
// In: clk, rst, eof, m00/m10/m01. Div link: div (master).
// Out: x, y, xy_valid, busy, empty_frame, err_timeout, overrun.
// Option: CENTROID_SMOOTH_EN averages each result with previous.
module centroid_div_sched
  import centroid_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eof,
  input  logic [MOM_W-1:0]   m00,
  input  logic [MOM_W-1:0]   m10,
  input  logic [MOM_W-1:0]   m01,
  centroid_div_sched_if.master div,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               xy_valid,
  output logic               busy,
  output logic               empty_frame,
  output logic               err_timeout,
  output logic               overrun
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(IMG_H - 1);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_START_X = START_X;
  localparam logic [2:0] ST_WAIT_X  = WAIT_X;
  localparam logic [2:0] ST_START_Y = START_Y;
  localparam logic [2:0] ST_WAIT_Y  = WAIT_Y;
  localparam logic [2:0] ST_DONE    = DONE;

  logic [2:0]         state_q, state_d;
  logic [MOM_W-1:0]   m00_s_q, m10_s_q, m01_s_q;
  logic [COORD_W-1:0] x_tmp_q, y_tmp_q, x_q, y_q;
  logic [COORD_W-1:0] x_d, y_d, x_clamp, y_clamp;
  logic [CNT_W-1:0]   cnt_q;
  logic               xy_valid_q, empty_q, err_q, ovr_q;
  logic               in_wait, tmo, y_phase;
`ifdef CENTROID_SMOOTH_EN
  logic               first_done_q;
  logic [COORD_W:0]   x_sum, y_sum;
`endif

  assign in_wait = (state_q == ST_WAIT_X)
                || (state_q == ST_WAIT_Y);
  assign y_phase = (state_q == ST_START_Y)
                || (state_q == ST_WAIT_Y);
  // qv on the last allowed wait cycle still wins over abort
  assign tmo = in_wait && !div.div_qv
            && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign busy        = (state_q != ST_IDLE);
  assign x           = x_q;
  assign y           = y_q;
  assign xy_valid    = xy_valid_q;
  assign empty_frame = empty_q;
  assign err_timeout = err_q;
  assign overrun     = ovr_q;

  assign div.div_start = (state_q == ST_START_X)
                      || (state_q == ST_START_Y);
  assign div.div_dividend = {
    {(DIVIDEND_W-MOM_W){1'b0}},
    y_phase ? m01_s_q : m10_s_q
  };
  assign div.div_divisor = {
    {(DIVISOR_W-MOM_W){1'b0}}, m00_s_q
  };

  coord_clamp u_clamp_x (
    .quo_i   (div.div_quotient),
    .lim_i   (X_LIM),
    .coord_o (x_clamp)
  );

  coord_clamp u_clamp_y (
    .quo_i   (div.div_quotient),
    .lim_i   (Y_LIM),
    .coord_o (y_clamp)
  );

`ifdef CENTROID_SMOOTH_EN
  always_comb begin
    x_sum = {1'b0, x_q} + {1'b0, x_tmp_q};
    y_sum = {1'b0, y_q} + {1'b0, y_tmp_q};
    x_d   = first_done_q ? x_sum[COORD_W:1] : x_tmp_q;
    y_d   = first_done_q ? y_sum[COORD_W:1] : y_tmp_q;
  end
`else
  always_comb begin
    x_d = x_tmp_q;
    y_d = y_tmp_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (eof && m00 != '0) state_d = ST_START_X;
      ST_START_X: state_d = ST_WAIT_X;
      ST_WAIT_X:
        if (div.div_qv)  state_d = ST_START_Y;
        else if (tmo)    state_d = ST_IDLE;
      ST_START_Y: state_d = ST_WAIT_Y;
      ST_WAIT_Y:
        if (div.div_qv)  state_d = ST_DONE;
        else if (tmo)    state_d = ST_IDLE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      m00_s_q    <= '0;
      m10_s_q    <= '0;
      m01_s_q    <= '0;
      x_tmp_q    <= '0;
      y_tmp_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      xy_valid_q <= 1'b0;
      empty_q    <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef CENTROID_SMOOTH_EN
      first_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      xy_valid_q <= 1'b0;
      // DONE counts as busy, so eof there is dropped too
      if (eof && busy) ovr_q <= 1'b1;
      if (state_q == ST_IDLE && eof) begin
        if (m00 == '0) begin
          empty_q <= 1'b1;
        end else begin
          m00_s_q <= m00;
          m10_s_q <= m10;
          m01_s_q <= m01;
        end
      end
      if (div.div_start) cnt_q <= '0;
      if (in_wait && !div.div_qv && !tmo)
        cnt_q <= cnt_q + CNT_W'(1);
      if (tmo) err_q <= 1'b1;
      if (state_q == ST_WAIT_X && div.div_qv)
        x_tmp_q <= x_clamp;
      if (state_q == ST_WAIT_Y && div.div_qv)
        y_tmp_q <= y_clamp;
      if (state_q == ST_DONE) begin
        x_q        <= x_d;
        y_q        <= y_d;
        xy_valid_q <= 1'b1;
        empty_q    <= 1'b0;
`ifdef CENTROID_SMOOTH_EN
        first_done_q <= 1'b1;
`endif
      end
    end
  end

endmodule
